// File: rtl/cla_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : cla_pkg                                               |
// | Brief    : Shared constants, types and configuration checks for  |
// |            the pipelined carry-look-ahead adder.                 |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
package cla_pkg;

   localparam int CLA_GROUP_W = 4;

   // Generate/propagate pair produced by one look-ahead group
   typedef struct packed {
      logic g;
      logic p;
   } cla_gp_t;

   // Valid configuration: at least one stage, each segment a whole number of groups
   function automatic bit cla_cfg_ok(input int width, input int stages);
      return (stages >= 1) && (width >= CLA_GROUP_W * stages) &&
             ((width % (CLA_GROUP_W * stages)) == 0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cla_group_4.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : cla_group_4                                           |
// | Brief    : 4-bit carry-look-ahead group; sum plus group          |
// |            generate/propagate for the second look-ahead level.   |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module cla_group_4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       gg,
   output logic       gp
);

   logic [3:0] w_g;
   logic [3:0] w_p;
   logic [3:0] w_c;

   assign w_g = a & b;
   assign w_p = a ^ b;

   // Fully flattened carries into each bit of the group
   assign w_c[0] = cin;
   assign w_c[1] = w_g[0] | (w_p[0] & cin);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0]) |
                   (w_p[2] & w_p[1] & w_p[0] & cin);

   assign sum = w_p ^ w_c;

   // Group terms are independent of cin so the parent can look ahead across groups
   assign gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1]) |
               (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
   assign gp = &w_p;

endmodule
`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : pipelined_cla_adder                                   |
// | Brief    : STAGES-deep pipelined CLA adder/subtractor with       |
// |            valid/ready handshake; carry registered per segment.  |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module pipelined_cla_adder
   import cla_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int SEG_W = WIDTH / STAGES;
   localparam int NGRP  = SEG_W / CLA_GROUP_W;

   if (!cla_cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
      $error("pipelined_cla_adder: WIDTH must be a multiple of 4*STAGES");
   end

   logic              w_en;
   logic [WIDTH-1:0]  w_b_eff;
   logic              w_c0;
   logic [STAGES-1:0] r_vld;
   logic [STAGES-1:0] w_co;
   logic [STAGES-1:0] r_cy;
   logic              w_ovf;
   logic              r_ovf;

   // Whole pipe advances together unless the output is held by the consumer
   assign w_en      = !r_vld[STAGES-1] || out_ready;
   assign in_ready  = w_en;
   assign out_valid = r_vld[STAGES-1];
   assign out_cout  = r_cy[STAGES-1];
   assign out_ovf   = r_ovf;

   // Subtraction is A + ~B + 1; in_cin is ignored then
   assign w_b_eff = in_sub ? ~in_b : in_b;
   assign w_c0    = in_sub | in_cin;

   // Per-stage valid bits shift with the pipe; bubbles travel as zeros
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld <= '0;
      end else if (w_en) begin
         r_vld[0] <= in_valid;
         for (int k = 1; k < STAGES; k++) begin
            r_vld[k] <= r_vld[k-1];
         end
      end
   end

   // Segment carry-outs and the final overflow flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cy  <= '0;
         r_ovf <= 1'b0;
      end else if (w_en) begin
         r_cy  <= w_co;
         r_ovf <= w_ovf;
      end
   end

   for (genvar j = 0; j < STAGES; j++) begin : g_seg
      logic [SEG_W-1:0]      w_a;
      logic [SEG_W-1:0]      w_b;
      logic [SEG_W-1:0]      w_s;
      logic                  w_cin;
      cla_gp_t [NGRP-1:0]    w_grp;
      logic [NGRP:0]         w_gc;
      logic [SEG_W-1:0]      r_ds [STAGES-j];

      if (j == 0) begin : g_first
         assign w_a   = in_a[SEG_W-1:0];
         assign w_b   = w_b_eff[SEG_W-1:0];
         assign w_cin = w_c0;
      end else begin : g_later
         logic [SEG_W-1:0] r_da [j];
         logic [SEG_W-1:0] r_db [j];

         // Operand slices wait j cycles to meet the carry rippling up from below
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int d = 0; d < j; d++) begin
                  r_da[d] <= '0;
                  r_db[d] <= '0;
               end
            end else if (w_en) begin
               r_da[0] <= in_a[j*SEG_W +: SEG_W];
               r_db[0] <= w_b_eff[j*SEG_W +: SEG_W];
               for (int d = 1; d < j; d++) begin
                  r_da[d] <= r_da[d-1];
                  r_db[d] <= r_db[d-1];
               end
            end
         end

         assign w_a   = r_da[j-1];
         assign w_b   = r_db[j-1];
         assign w_cin = r_cy[j-1];
      end

      for (genvar g = 0; g < NGRP; g++) begin : g_grp
         cla_group_4 u_grp (
            .a   (w_a[g*CLA_GROUP_W +: CLA_GROUP_W]),
            .b   (w_b[g*CLA_GROUP_W +: CLA_GROUP_W]),
            .cin (w_gc[g]),
            .sum (w_s[g*CLA_GROUP_W +: CLA_GROUP_W]),
            .gg  (w_grp[g].g),
            .gp  (w_grp[g].p)
         );
      end

      // Second look-ahead level: each group carry as a sum of products of GG/GP
      always_comb begin
         logic v_c;
         logic v_p;
         v_c     = 1'b0;
         v_p     = 1'b1;
         w_gc    = '0;
         w_gc[0] = w_cin;
         for (int n = 1; n <= NGRP; n++) begin
            v_c = 1'b0;
            v_p = 1'b1;
            for (int h = n - 1; h >= 0; h--) begin
               v_c = v_c | (v_p & w_grp[h].g);
               v_p = v_p & w_grp[h].p;
            end
            w_gc[n] = v_c | (v_p & w_cin);
         end
      end

      assign w_co[j] = w_gc[NGRP];

      // Sum slice registered at its stage, then skewed so all slices exit together
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int d = 0; d < STAGES - j; d++) begin
               r_ds[d] <= '0;
            end
         end else if (w_en) begin
            r_ds[0] <= w_s;
            for (int d = 1; d < STAGES - j; d++) begin
               r_ds[d] <= r_ds[d-1];
            end
         end
      end

      assign out_sum[j*SEG_W +: SEG_W] = r_ds[STAGES-j-1];

      if (j == STAGES - 1) begin : g_msb
         // Carry into the MSB recovered from its sum bit: c = s ^ a ^ b'
         assign w_ovf = (w_s[SEG_W-1] ^ w_a[SEG_W-1] ^ w_b[SEG_W-1]) ^ w_gc[NGRP];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_pipelined_cla_adder                                |
// | Brief    : Self-checking bench: directed vector table, stall and |
// |            reset sequences, random sweep over three configs.     |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module tb_pipelined_cla_adder;

   localparam int W    = 32;
   localparam int S    = 2;
   localparam int RCYC = 6000;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, in_cin, in_sub;
   logic          out_valid, out_ready, out_cout, out_ovf;
   logic [W-1:0]  in_a, in_b, out_sum;
   bit            rand_go = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pipelined_cla_adder #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [31:0] s;
      logic        co;
      logic        ov;
   } vec_t;

   vec_t tbl [10];

   // {ovf, cout, sum} from plain arithmetic on the effective operands
   function automatic logic [33:0] ref32(input logic [31:0] x, y, input logic c, m);
      logic [31:0] yp;
      logic [32:0] f;
      logic        v;
      yp = m ? ~y : y;
      f  = {1'b0, x} + {1'b0, yp} + {32'd0, (m | c)};
      v  = (x[31] == yp[31]) && (f[31] != x[31]);
      return {v, f};
   endfunction

   task automatic run_vec(input vec_t v, input string tag);
      int cyc;
      @(negedge clk);
      in_a = v.a; in_b = v.b; in_cin = v.cin; in_sub = v.sub;
      in_valid = 1'b1; out_ready = 1'b1;
      #1 chk({tag, "_rdy"}, in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_lat"}, cyc, S);
      chk({tag, "_sum"}, out_sum, v.s);
      chk({tag, "_cout"}, out_cout, v.co);
      chk({tag, "_ovf"}, out_ovf, v.ov);
   endtask

   initial begin
      logic [31:0] ba [8];
      logic [31:0] bb [8];
      logic        bc [8];
      logic        bs [8];
      logic [33:0] expq [$];
      logic [33:0] held;
      logic [33:0] e;
      int          sent, got, stall, t;
      bit          seen, have_held;

      tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      tbl[2] = '{32'd5,         32'd7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      tbl[3] = '{32'd7,         32'd5,         1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
      tbl[4] = '{32'd0,         32'd0,         1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
      tbl[5] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
      tbl[6] = '{32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      tbl[7] = '{32'd3,         32'd3,         1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      tbl[8] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
      tbl[9] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_sum", out_sum, 32'h0);
      chk("rst_cout", out_cout, 1'b0);
      chk("rst_ovf", out_ovf, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", in_ready, 1'b1);

      for (int i = 0; i < 10; i++) begin
         run_vec(tbl[i], $sformatf("vec%0d", i));
      end

      // Eight back-to-back transactions with a three-cycle stall
      for (int i = 0; i < 8; i++) begin
         ba[i] = $urandom; bb[i] = $urandom;
         bc[i] = 1'($urandom_range(0, 1)); bs[i] = 1'($urandom_range(0, 1));
      end
      sent = 0; got = 0; stall = 0; seen = 1'b0; have_held = 1'b0; held = '0;
      for (int c = 0; c < 40 && got < 8; c++) begin
         @(negedge clk);
         in_valid = (sent < 8);
         if (sent < 8) begin
            in_a = ba[sent]; in_b = bb[sent]; in_cin = bc[sent]; in_sub = bs[sent];
         end
         if (stall > 0) begin
            out_ready = 1'b0;
            stall--;
         end else begin
            out_ready = 1'b1;
         end
         #1;
         if (!out_ready) begin
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_valid_held", out_valid, 1'b1);
            if (!have_held) begin
               held = {out_ovf, out_cout, out_sum};
               have_held = 1'b1;
            end else begin
               chk("bp_hold", {out_ovf, out_cout, out_sum}, held);
            end
         end
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               chk("bp_extra", 1'b1, 1'b0);
            end else begin
               e = expq.pop_front();
               chk($sformatf("bp_res%0d", got), {out_ovf, out_cout, out_sum}, e);
            end
            got++;
            if (!seen) begin
               seen = 1'b1;
               stall = 3;
            end
         end
         if (in_valid && in_ready) begin
            expq.push_back(ref32(in_a, in_b, in_cin, in_sub));
            sent++;
         end
      end
      chk("bp_got", got, 8);
      chk("bp_sent", sent, 8);
      chk("bp_left", expq.size(), 0);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);

      // Asynchronous reset with two transactions in flight
      in_a = 32'hFFFF_FFFF; in_b = 32'h2; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_a = 32'h1234_5678; in_b = 32'h1111_1111;
      @(posedge clk);
      in_valid = 1'b0;
      #1 chk("mid_valid_before", out_valid, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_sum", out_sum, 32'h0);
      chk("mid_rst_cout", out_cout, 1'b0);
      chk("mid_rst_ready", in_ready, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("post_rst_idle", out_valid, 1'b0);
      end
      run_vec(tbl[1], "post_rst");

      // Random sweep across configurations
      rand_go = 1'b1;
      t = 0;
      while (!(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done) && t < RCYC + 200) begin
         @(negedge clk);
         t++;
      end
      chk("rand_done", {g_rnd[2].done, g_rnd[1].done, g_rnd[0].done}, 3'b111);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   for (genvar k = 0; k < 3; k++) begin : g_rnd
      localparam int GW = (k == 0) ? 32 : (k == 1) ? 16 : 64;
      localparam int GS = (k == 0) ? 2  : (k == 1) ? 1  : 4;

      logic          rr, iv, ir, ov, ordy, ci, sb, co, of;
      logic [GW-1:0] a, b, s;
      logic [GW+1:0] q [$];
      bit            done = 1'b0;

      pipelined_cla_adder #(.WIDTH(GW), .STAGES(GS)) u_dut (
         .clk(clk), .rst(rr),
         .in_valid(iv), .in_ready(ir),
         .in_a(a), .in_b(b), .in_cin(ci), .in_sub(sb),
         .out_valid(ov), .out_ready(ordy),
         .out_sum(s), .out_cout(co), .out_ovf(of)
      );

      function automatic logic [GW+1:0] model(input logic [GW-1:0] x, y, input logic c, m);
         logic [GW-1:0] yp;
         logic [GW:0]   f;
         logic          v;
         yp = m ? ~y : y;
         f  = {1'b0, x} + {1'b0, yp} + {{GW{1'b0}}, (m | c)};
         v  = (x[GW-1] == yp[GW-1]) && (f[GW-1] != x[GW-1]);
         return {v, f};
      endfunction

      function automatic logic [GW-1:0] rop();
         logic [127:0] r;
         r = {$urandom, $urandom, $urandom, $urandom};
         case ($urandom_range(0, 7))
            0:       return '1;
            1:       return '0;
            2:       return {1'b1, {(GW-1){1'b0}}};
            3:       return {1'b0, {(GW-1){1'b1}}};
            default: return r[GW-1:0];
         endcase
      endfunction

      task automatic step();
         logic [GW+1:0] e;
         chk($sformatf("rnd%0d_ready", k), ir, (!ov || ordy));
         if (ov && ordy) begin
            if (q.size() == 0) begin
               chk($sformatf("rnd%0d_extra", k), 1'b1, 1'b0);
            end else begin
               e = q.pop_front();
               chk($sformatf("rnd%0d_res", k), {of, co, s}, e);
            end
         end
         if (iv && ir) begin
            q.push_back(model(a, b, ci, sb));
         end
      endtask

      initial begin
         rr = 1'b1; iv = 1'b0; ordy = 1'b0;
         a = '0; b = '0; ci = 1'b0; sb = 1'b0;
         wait (rand_go);
         @(negedge clk);
         rr = 1'b0;
         for (int c = 0; c < RCYC; c++) begin
            @(negedge clk);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            a    = rop();
            b    = rop();
            ci   = 1'($urandom_range(0, 1));
            sb   = 1'($urandom_range(0, 1));
            #1 step();
         end
         @(negedge clk);
         iv = 1'b0; ordy = 1'b1;
         for (int c = 0; c < 3 * GS + 4 && q.size() > 0; c++) begin
            #1 step();
            @(negedge clk);
         end
         chk($sformatf("rnd%0d_left", k), q.size(), 0);
         done = 1'b1;
      end
   end

endmodule
`default_nettype wire
